// File: rtl/montgomery_pkg.sv
// Shared definitions for the Montgomery constant generator and, later,
// the Montgomery multiplier that consumes its R / R^2 mod N results.
package montgomery_pkg;

    // Controller states of the constant generator.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FIND_R   = 3'd1,
        ST_INIT_ACC = 3'd2,
        ST_DOUBLE   = 3'd3,
        ST_FINISH   = 3'd4
    } state_t;

    // Smallest modulus accepted; anything below (or even) is rejected.
    localparam int unsigned MIN_MODULUS = 32'd3;

endpackage

// File: rtl/montgomery_const_gen_mod_double_step.sv
// One modular doubling step: result = (2 * acc) mod modulus.
// Assumes acc < modulus, so a single conditional subtraction suffices.
module mod_double_step #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0] modulus,
    output logic [DATA_WIDTH-1:0] result
);

    logic [DATA_WIDTH:0] t_s;
    logic                ge_s;

    assign t_s = {acc, 1'b0};

    // The carry-out bit alone already proves t >= modulus.
    assign ge_s = t_s[DATA_WIDTH] | (t_s[DATA_WIDTH-1:0] >= modulus);

    // Conditional subtraction; the true difference is below modulus,
    // so the low DATA_WIDTH bits of the wrapped subtraction are exact.
    always_comb begin
        if (ge_s) begin
            result = t_s[DATA_WIDTH-1:0] - modulus;
        end else begin
            result = t_s[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/montgomery_const_gen.sv
// Montgomery constant generator: for an odd modulus N >= 3 computes
// k = bitlength(N), R = 2^k and R^2 mod N using only shifts, compares
// and subtractions. Illegal moduli complete immediately with error set.
module montgomery_const_gen
    import montgomery_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    localparam int K_WIDTH    = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] modulant,
    output logic [DATA_WIDTH:0]   R_out,
    output logic [DATA_WIDTH-1:0] R2_out,
    output logic [K_WIDTH-1:0]    k_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    state_t                  state_r;
    state_t                  state_next_s;
    logic [DATA_WIDTH-1:0]   n_r;
    logic [DATA_WIDTH:0]     r_r;
    logic [K_WIDTH-1:0]      k_r;
    logic [K_WIDTH-1:0]      cnt_r;
    logic [DATA_WIDTH-1:0]   acc_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    error_r;

    logic                    legal_s;
    logic                    r_le_n_s;
    logic [DATA_WIDTH-1:0]   r_mod_n_s;
    logic [DATA_WIDTH-1:0]   step_s;

    // Modulus must be odd and at least MIN_MODULUS.
    assign legal_s   = modulant[0] & (modulant >= DATA_WIDTH'(MIN_MODULUS));
    assign r_le_n_s  = (r_r <= {1'b0, n_r});
    // N < R < 2N for odd N, so R mod N is a single subtraction whose
    // result fits in DATA_WIDTH bits.
    assign r_mod_n_s = r_r[DATA_WIDTH-1:0] - n_r;

    mod_double_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_double (
        .acc     (acc_r),
        .modulus (n_r),
        .result  (step_s)
    );

    // Next-state selection for the controller.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (legal_s) begin
                        state_next_s = ST_FIND_R;
                    end else begin
                        state_next_s = ST_FINISH;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FIND_R: begin
                if (r_le_n_s) begin
                    state_next_s = ST_FIND_R;
                end else begin
                    state_next_s = ST_INIT_ACC;
                end
            end
            ST_INIT_ACC: begin
                state_next_s = ST_DOUBLE;
            end
            ST_DOUBLE: begin
                if (cnt_r == K_WIDTH'(1)) begin
                    state_next_s = ST_FINISH;
                end else begin
                    state_next_s = ST_DOUBLE;
                end
            end
            ST_FINISH: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register, status flags and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            n_r     <= '0;
            r_r     <= '0;
            k_r     <= '0;
            cnt_r   <= '0;
            acc_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
            // done is high exactly while the FSM sits in FINISH.
            done_r  <= (state_next_s == ST_FINISH);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        n_r   <= modulant;
                        k_r   <= '0;
                        cnt_r <= '0;
                        acc_r <= '0;
                        if (legal_s) begin
                            r_r     <= {{DATA_WIDTH{1'b0}}, 1'b1};
                            error_r <= 1'b0;
                        end else begin
                            // Rejected modulus: report zeros with error,
                            // raised together with done.
                            r_r     <= '0;
                            error_r <= 1'b1;
                        end
                    end else begin
                        n_r <= n_r;
                    end
                end
                ST_FIND_R: begin
                    if (r_le_n_s) begin
                        r_r <= r_r << 1;
                        k_r <= k_r + K_WIDTH'(1);
                    end else begin
                        r_r <= r_r;
                    end
                end
                ST_INIT_ACC: begin
                    acc_r <= r_mod_n_s;
                    cnt_r <= k_r;
                end
                ST_DOUBLE: begin
                    // k doublings of R mod N yield R * 2^k mod N = R^2 mod N.
                    acc_r <= step_s;
                    cnt_r <= cnt_r - K_WIDTH'(1);
                end
                ST_FINISH: begin
                    acc_r <= acc_r;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign R_out  = r_r;
    assign R2_out = acc_r;
    assign k_out  = k_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign error  = error_r;

endmodule

// File: tb/tb_montgomery_const_gen.sv
// Self-checking bench for montgomery_const_gen: directed corner cases plus
// randomized moduli checked against an arithmetic reference model, on an
// 8-bit and a 16-bit instance.
module tb_montgomery_const_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start16;
    logic [7:0]  modulant8;
    logic [15:0] modulant16;
    logic [8:0]  r8;
    logic [7:0]  r2_8;
    logic [3:0]  k8;
    logic        busy8, done8, error8;
    logic [16:0] r16;
    logic [15:0] r2_16;
    logic [4:0]  k16;
    logic        busy16, done16, error16;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    montgomery_const_gen #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .modulant(modulant8),
        .R_out(r8), .R2_out(r2_8), .k_out(k8),
        .busy(busy8), .done(done8), .error(error8)
    );

    montgomery_const_gen #(.DATA_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .modulant(modulant16),
        .R_out(r16), .R2_out(r2_16), .k_out(k16),
        .busy(busy16), .done(done16), .error(error16)
    );

    // Reference model: results straight from the definition.
    function automatic bit ref_legal(input longint unsigned n);
        return (n % 2 == 1) && (n >= 3);
    endfunction

    function automatic longint unsigned ref_k(input longint unsigned n);
        longint unsigned k = 0;
        if (!ref_legal(n)) return 0;
        while ((64'd1 << k) <= n) k++;
        return k;
    endfunction

    function automatic longint unsigned ref_r(input longint unsigned n);
        if (!ref_legal(n)) return 0;
        return 64'd1 << ref_k(n);
    endfunction

    function automatic longint unsigned ref_r2(input longint unsigned n);
        longint unsigned r;
        if (!ref_legal(n)) return 0;
        r = ref_r(n);
        return (r * r) % n;
    endfunction

    function automatic int ref_cycles(input longint unsigned n);
        if (!ref_legal(n)) return 1;
        return 2 * int'(ref_k(n)) + 3;
    endfunction

    function automatic bit cur_done(input bit wide);
        return wide ? done16 : done8;
    endfunction

    // Drive start for exactly one sampling edge; returns #1 after that edge.
    task automatic pulse_start(input bit wide, input logic [15:0] n);
        if (wide) begin
            start16 = 1'b1; modulant16 = n;
        end else begin
            start8 = 1'b1; modulant8 = n[7:0];
        end
        @(posedge clk); #1;
        start8 = 1'b0; start16 = 1'b0;
    endtask

    // Count edges (sampling edge = 1) until done; -1 when the bound expires.
    task automatic wait_done(input bit wide, output int cyc);
        cyc = 1;
        while (!cur_done(wide) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!cur_done(wide)) cyc = -1;
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(); step();
        n_cmp++;
        if ({r8, r2_8, k8, busy8, done8, error8} !== 24'd0) begin
            n_bad++;
            $display("FAIL reset8: got %h required 0", {r8, r2_8, k8, busy8, done8, error8});
        end
        n_cmp++;
        if ({r16, r2_16, k16, busy16, done16, error16} !== 41'd0) begin
            n_bad++;
            $display("FAIL reset16: got %h required 0", {r16, r2_16, k16, busy16, done16, error16});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_directed;
        int cyc;
        logic [7:0] nlist [2] = '{8'd13, 8'd255};
        int         clist [2] = '{11, 19};
        int         rlist [2] = '{16, 256};
        int         klist [2] = '{4, 8};
        int         qlist [2] = '{9, 1};
        for (int i = 0; i < 2; i++) begin
            pulse_start(1'b0, {8'd0, nlist[i]});
            wait_done(1'b0, cyc);
            n_cmp++;
            if (cyc != clist[i] || int'(r8) != rlist[i] || int'(k8) != klist[i] ||
                int'(r2_8) != qlist[i] || error8 !== 1'b0) begin
                n_bad++;
                $display("FAIL directed N=%0d: got cyc=%0d R=%0d k=%0d R2=%0d err=%b required cyc=%0d R=%0d k=%0d R2=%0d err=0",
                         nlist[i], cyc, r8, k8, r2_8, error8, clist[i], rlist[i], klist[i], qlist[i]);
            end
            step();
            n_cmp++;
            if (done8 !== 1'b0 || busy8 !== 1'b0 || int'(r8) != rlist[i]) begin
                n_bad++;
                $display("FAIL directed_after N=%0d: got done=%b busy=%b R=%0d required 0/0/%0d",
                         nlist[i], done8, busy8, r8, rlist[i]);
            end
        end
    endtask

    task automatic test_illegal;
        int cyc;
        logic [7:0] nlist [4] = '{8'd12, 8'd1, 8'd0, 8'd2};
        for (int i = 0; i < 4; i++) begin
            pulse_start(1'b0, {8'd0, nlist[i]});
            wait_done(1'b0, cyc);
            n_cmp++;
            if (cyc != 1 || error8 !== 1'b1 || r8 !== 9'd0 || r2_8 !== 8'd0 || k8 !== 4'd0) begin
                n_bad++;
                $display("FAIL illegal N=%0d: got cyc=%0d err=%b R=%0d R2=%0d k=%0d required 1/1/0/0/0",
                         nlist[i], cyc, error8, r8, r2_8, k8);
            end
            step();
            n_cmp++;
            if (error8 !== 1'b1 || done8 !== 1'b0) begin
                n_bad++;
                $display("FAIL illegal_hold N=%0d: got err=%b done=%b required 1/0", nlist[i], error8, done8);
            end
        end
    endtask

    task automatic test_random;
        int cyc;
        longint unsigned n;
        for (int i = 0; i < 24; i++) begin
            n = longint'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) n = n | 64'd1;
            pulse_start(1'b0, n[15:0]);
            n_cmp++;
            if (busy8 !== 1'b1) begin
                n_bad++;
                $display("FAIL rand_busy N=%0d: got %b required 1", n, busy8);
            end
            modulant8 = 8'($urandom_range(0, 255));
            wait_done(1'b0, cyc);
            n_cmp++;
            if (cyc != ref_cycles(n) || 64'(r8) != ref_r(n) || 64'(r2_8) != ref_r2(n) ||
                64'(k8) != ref_k(n) || error8 !== !ref_legal(n)) begin
                n_bad++;
                $display("FAIL random N=%0d: got cyc=%0d R=%0d R2=%0d k=%0d err=%b required cyc=%0d R=%0d R2=%0d k=%0d err=%b",
                         n, cyc, r8, r2_8, k8, error8, ref_cycles(n), ref_r(n), ref_r2(n), ref_k(n), !ref_legal(n));
            end
            step(); step();
            n_cmp++;
            if (done8 !== 1'b0 || 64'(r8) != ref_r(n) || 64'(r2_8) != ref_r2(n)) begin
                n_bad++;
                $display("FAIL random_hold N=%0d: got done=%b R=%0d R2=%0d required 0/%0d/%0d",
                         n, done8, r8, r2_8, ref_r(n), ref_r2(n));
            end
        end
    endtask

    task automatic test_wide;
        int cyc;
        longint unsigned n;
        for (int i = 0; i < 6; i++) begin
            n = (i == 0) ? 64'd65521 : (longint'($urandom_range(3, 65535)) | 64'd1);
            pulse_start(1'b1, n[15:0]);
            wait_done(1'b1, cyc);
            n_cmp++;
            if (cyc != ref_cycles(n) || 64'(r16) != ref_r(n) || 64'(r2_16) != ref_r2(n) ||
                64'(k16) != ref_k(n) || error16 !== 1'b0) begin
                n_bad++;
                $display("FAIL wide N=%0d: got cyc=%0d R=%0d R2=%0d k=%0d err=%b required cyc=%0d R=%0d R2=%0d k=%0d err=0",
                         n, cyc, r16, r2_16, k16, error16, ref_cycles(n), ref_r(n), ref_r2(n), ref_k(n));
            end
            step();
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        int pulses = 0;
        int first = -1;
        logic [8:0] r_at;
        logic [7:0] r2_at;
        pulse_start(1'b0, 16'd13);
        for (int c = 2; c <= 5; c++) step();
        start8 = 1'b1; modulant8 = 8'd7;
        step();
        start8 = 1'b0;
        r_at = '0; r2_at = '0;
        for (int c = 6; c <= 40; c++) begin
            if (done8 === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = c; r_at = r8; r2_at = r2_8;
                end
            end
            step();
        end
        n_cmp++;
        if (pulses != 1 || first != 11 || r_at !== 9'd16 || r2_at !== 8'd9) begin
            n_bad++;
            $display("FAIL restart_ignored: got pulses=%0d at=%0d R=%0d R2=%0d required 1/11/16/9",
                     pulses, first, r_at, r2_at);
        end
        // start raised during the done cycle must be ignored.
        pulse_start(1'b0, 16'd13);
        wait_done(1'b0, cyc);
        start8 = 1'b1; modulant8 = 8'd7;
        step();
        start8 = 1'b0;
        step();
        n_cmp++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || r8 !== 9'd16) begin
            n_bad++;
            $display("FAIL start_on_done: got busy=%b done=%b R=%0d required 0/0/16", busy8, done8, r8);
        end
    endtask

    task automatic test_rst_mid;
        int cyc;
        int pulses = 0;
        pulse_start(1'b0, 16'd13);
        for (int c = 2; c <= 6; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({busy8, done8, error8, r8, r2_8, k8} !== 24'd0) begin
            n_bad++;
            $display("FAIL rst_mid: got %h required 0", {busy8, done8, error8, r8, r2_8, k8});
        end
        for (int c = 0; c < 20; c++) begin
            if (done8 === 1'b1) pulses++;
            step();
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL rst_no_done: got %0d pulses required 0", pulses);
        end
        pulse_start(1'b0, 16'd7);
        wait_done(1'b0, cyc);
        n_cmp++;
        if (cyc != 9 || r8 !== 9'd8 || r2_8 !== 8'd1 || k8 !== 4'd3 || error8 !== 1'b0) begin
            n_bad++;
            $display("FAIL after_rst N=7: got cyc=%0d R=%0d R2=%0d k=%0d err=%b required 9/8/1/3/0",
                     cyc, r8, r2_8, k8, error8);
        end
        step();
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; start16 = 1'b0;
        modulant8 = 8'd0; modulant16 = 16'd0;
        #1;
        test_reset();
        test_directed();
        test_illegal();
        test_random();
        test_wide();
        test_back_to_back();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/montgomery_const_gen.md
MONTGOMERY_CONST_GEN -- requirements
Module: montgomery_const_gen

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the modulus width in bits, legal range 4..64.
REQ-002 The block SHALL have derived localparam K_WIDTH = $clog2(DATA_WIDTH+1), the width of the exponent counter.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  request pulse, sampled only in IDLE.
REQ-007 modulant  input  DATA_WIDTH  modulus N, captured on the accepted start.
REQ-008 R_out  output  DATA_WIDTH+1  R = 2^k, the smallest power of two strictly greater than N.
REQ-009 R2_out  output  DATA_WIDTH  R^2 mod N.
REQ-010 k_out  output  K_WIDTH  exponent k, equal to the bit length of N.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 error  output  1  high with done when N is illegal; held until the next accepted start.

Function
REQ-014 The FSM SHALL have states IDLE, FIND_R, INIT_ACC, DOUBLE and FINISH.
REQ-015 IDLE SHALL accept a start: latch N, set R=1, k=0, clear error, go to FIND_R; when busy=1, start SHALL be ignored.
REQ-016 If the captured N is even or N<3, the block SHALL go to FINISH with error=1 and R_out, R2_out, k_out = 0, instead of entering FIND_R.
REQ-017 FIND_R SHALL act each cycle as follows: if R<=N, then R<=R<<1 and k<=k+1; otherwise go to INIT_ACC.
REQ-018 INIT_ACC SHALL set acc=R-N (R mod N, valid because N<R<2N for odd N), set the loop counter to k, and go to DOUBLE.
REQ-019 Each DOUBLE cycle SHALL form t={acc,0} (DATA_WIDTH+1 bits), set acc=t-N if t>=N else acc=t, and decrement the counter.
REQ-020 DOUBLE SHALL leave for FINISH after exactly k iterations, with acc = R^2 mod N.
REQ-021 FINISH SHALL assert done for exactly one cycle, then return to IDLE.
REQ-022 For a legal N, done SHALL be high exactly 2k+3 cycles after the edge that samples start.
REQ-023 For an illegal N, done SHALL be high exactly 1 cycle after the edge that samples start.
REQ-024 R_out, R2_out and k_out SHALL hold the last result from FINISH until the next accepted start.
REQ-025 During a computation, R_out, R2_out and k_out SHALL show intermediate values and are valid only from the done cycle onward.
REQ-026 An input change on modulant after start SHALL NOT affect the running computation.
REQ-027 N = 2^DATA_WIDTH-1 SHALL give R=2^DATA_WIDTH without overflow of R_out.
REQ-028 start asserted in the same cycle as done SHALL be ignored, because the FSM is not yet in IDLE.

Reset
REQ-029 rst SHALL force state IDLE and set R_out, R2_out, k_out, busy, done, error and all internal registers to 0.
REQ-030 rst SHALL take priority over start.
REQ-031 rst asserted mid-computation SHALL abort it with no done pulse.
REQ-032 The first start accepted after rst SHALL behave as from power-up.

Structure
REQ-033 Package montgomery_pkg SHALL hold the state typedef (enum logic [2:0]) and the MIN_MODULUS=3 constant, for reuse by the future Montgomery multiplier.
REQ-034 Sub-module mod_double_step (combinational: acc, N -> (2*acc) mod N, DATA_WIDTH parameter) SHALL implement REQ-019.
REQ-035 All other logic SHALL stay in montgomery_const_gen.

Verification
REQ-036 DATA_WIDTH=8, N=13, start -> done at cycle 11, R_out=16, k_out=4, R2_out=9, error=0.
REQ-037 DATA_WIDTH=8, N=255 -> R_out=256, k_out=8, R2_out=1, done at cycle 19.
REQ-038 DATA_WIDTH=16, N=65521 -> R_out=65536, k_out=16, R2_out=225.
REQ-039 N=12, then N=1 -> done at cycle 1, error=1, R_out=0, R2_out=0.
REQ-040 N=13 with start re-pulsed at cycle 5 and modulant changed to 7 -> result still 16/9, with exactly one done pulse.
REQ-041 N=13 with rst at cycle 6 -> busy=0 and all outputs 0 next cycle, with no done; a following start with N=7 -> R_out=8, R2_out=1.
